regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_ctrl_pkg.sv | 20 ++
 rtl/regfile_wb_arbiter_rr.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_ctrl_pkg
// Purpose  : Shared definitions for the register-file write-back arbiter:
//            controller state encoding and the byte-width constant.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package regfile_ctrl_pkg;

  localparam int BYTE = 8;

  // CLEAR: zero-fill sequence running. ARB: normal write-back arbitration.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin grant. The search for a set request starts at
//            index ptr and wraps around; the first hit is granted.
// Ports    : req   [N-1:0]   request vector
//            ptr   [PW-1:0]  index of the highest-priority requester (< N)
//            grant [N-1:0]   one-hot grant, or zero when req is zero
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]                      req,
  input  logic [$clog2((N > 1) ? N : 2)-1:0] ptr,
  output logic [N-1:0]                      grant
);

  logic [N-1:0] rot;
  logic [N-1:0] rot_oh;

  // Rotate so that requester ptr sits at bit 0, isolate the lowest set bit,
  // then rotate the one-hot result back into requester order.
  always_comb begin
    rot    = N'({req, req} >> ptr);
    rot_oh = rot & (~rot + N'(1));
    grant  = N'(({rot_oh, rot_oh} << ptr) >> N);
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Arbitrates several write-back sources onto a single register-file
//            write port and performs a zero-fill of the whole file after reset
//            or on request.
// Ports    : clk, reset            clock, asynchronous active-high reset
//            req_valid/addr/be/data per-requester write requests
//            req_ready             combinational one-hot acceptance
//            clear_req             pulse: zero-fill all registers
//            clear_busy            high while fill writes are on the port
//            Reg_wr/wr_addr/wr_data registered register-file write port
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int WORD       = 16,
  parameter int REGISTERS  = 8,
  parameter int REQUESTERS = 2
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [REQUESTERS-1:0]                            req_valid,
  input  logic [REQUESTERS-1:0][$clog2(REGISTERS)-1:0]     req_addr,
  input  logic [REQUESTERS-1:0][WORD/BYTE-1:0]             req_be,
  input  logic [REQUESTERS-1:0][WORD-1:0]                  req_data,
  output logic [REQUESTERS-1:0]                            req_ready,
  input  logic                                             clear_req,
  output logic                                             clear_busy,
  output logic [WORD/BYTE-1:0]                             Reg_wr,
  output logic [$clog2(REGISTERS)-1:0]                     wr_addr,
  output logic [WORD-1:0]                                  wr_data
);

  localparam int AW = $clog2(REGISTERS);
  localparam int BW = WORD / BYTE;
  localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [BW-1:0]   reg_wr_q, reg_wr_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD-1:0] wr_data_q, wr_data_d;
  logic            clear_busy_q, clear_busy_d;

  logic [REQUESTERS-1:0] grant;
  logic [BW-1:0]         sel_be;
  logic [AW-1:0]         sel_addr;
  logic [WORD-1:0]       sel_data;
  logic [PW-1:0]         nxt_ptr;

  rr_arbiter #(
    .N (REQUESTERS)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Select the granted request and the requester after it (new priority).
  always_comb begin
    sel_be   = '0;
    sel_addr = '0;
    sel_data = '0;
    nxt_ptr  = ptr_q;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant[i]) begin
        sel_be   = req_be[i];
        sel_addr = req_addr[i];
        sel_data = req_data[i];
        nxt_ptr  = PW'((i + 1) % REQUESTERS);
      end
    end
  end

  assign req_ready = (state_q == ARB) ? grant : '0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    reg_wr_d     = '0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    // Busy follows the write port: it is high for each cycle a fill write
    // is presented, so it trails the state register by one cycle.
    clear_busy_d = (state_q == CLEAR);
    case (state_q)
      CLEAR: begin
        reg_wr_d  = '1;
        wr_addr_d = cnt_q;
        wr_data_d = '0;
        if (cnt_q == AW'(REGISTERS - 1)) begin
          cnt_d   = '0;
          state_d = ARB;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ARB: begin
        if (|grant) begin
          reg_wr_d  = sel_be;
          wr_addr_d = sel_addr;
          wr_data_d = sel_data;
          ptr_d     = nxt_ptr;
        end
        // A request granted in this cycle still issues before the fill.
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CLEAR;
      cnt_q        <= '0;
      ptr_q        <= '0;
      reg_wr_q     <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      clear_busy_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      reg_wr_q     <= reg_wr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      clear_busy_q <= clear_busy_d;
    end
  end

  assign Reg_wr     = reg_wr_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign clear_busy = clear_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Self-checking bench for regfile_wb_arbiter with a behavioural
//            reference model and an expected-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int W  = 16;
  localparam int R  = 8;
  localparam int N  = 2;
  localparam int AW = 3;
  localparam int BW = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [N-1:0]          req_valid = '0;
  logic [N-1:0][AW-1:0]  req_addr = '0;
  logic [N-1:0][BW-1:0]  req_be = '0;
  logic [N-1:0][W-1:0]   req_data = '0;
  logic [N-1:0]          req_ready;
  logic                  clear_req = 1'b0;
  logic                  clear_busy;
  logic [BW-1:0]         Reg_wr;
  logic [AW-1:0]         wr_addr;
  logic [W-1:0]          wr_data;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .WORD       (W),
    .REGISTERS  (R),
    .REQUESTERS (N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .Reg_wr     (Reg_wr),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  typedef struct {
    logic [BW-1:0] wr;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic          busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state: fill progress, priority pointer, port hold values.
  bit            m_fill;
  int            m_cnt;
  int            m_ptr;
  logic [AW-1:0] m_la;
  logic [W-1:0]  m_ld;

  task automatic model_reset();
    m_fill = 1'b1;
    m_cnt  = 0;
    m_ptr  = 0;
    m_la   = '0;
    m_ld   = '0;
  endtask

  // Called at a falling edge with inputs already driven: predicts the write
  // for the coming rising edge, checks req_ready, waits for next falling edge.
  task automatic step();
    exp_t         e;
    int           g;
    logic [N-1:0] er;
    g  = -1;
    er = '0;
    if (m_fill) begin
      e.wr   = '1;
      e.a    = AW'(m_cnt);
      e.d    = '0;
      e.busy = 1'b1;
      m_cnt++;
      if (m_cnt == R) m_fill = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      if (g >= 0) begin
        er[g] = 1'b1;
        e.wr  = req_be[g];
        e.a   = req_addr[g];
        e.d   = req_data[g];
        m_ptr = (g + 1) % N;
      end else begin
        e.wr = '0;
        e.a  = m_la;
        e.d  = m_ld;
      end
      e.busy = 1'b0;
      if (clear_req) begin
        m_fill = 1'b1;
        m_cnt  = 0;
      end
    end
    m_la = e.a;
    m_ld = e.d;
    sb.push_back(e);
    #1;
    checks++;
    if (req_ready === er) passed++;
    else $display("FAIL req_ready: got %b want %b (t=%0t)", req_ready, er, $time);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    checks++;
    if (Reg_wr === '0 && wr_addr === '0 && wr_data === '0 &&
        clear_busy === 1'b1 && req_ready === '0)
      passed++;
    else
      $display("FAIL reset_state: got wr=%b a=%0d d=%h busy=%b rdy=%b want wr=0 a=0 d=0 busy=1 rdy=0",
               Reg_wr, wr_addr, wr_data, clear_busy, req_ready);
  endtask

  // Asserted between edges so the forced values must come from the
  // asynchronous reset path alone.
  task automatic do_reset();
    #2 reset = 1'b1;
    sb.delete();
    #1 check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_req(input int i, input bit v, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [W-1:0] d);
    req_valid[i] = v;
    req_addr[i]  = a;
    req_be[i]    = be;
    req_data[i]  = d;
  endtask

  task automatic idle();
    req_valid = '0;
    clear_req = 1'b0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++)
      set_req(i, 1'($urandom), AW'($urandom), BW'($urandom), W'($urandom));
    clear_req = ($urandom_range(0, 19) == 0);
  endtask

  // Monitor: compares the write port against the scoreboard after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL scoreboard: DUT edge with no expected entry (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        if (Reg_wr === e.wr && wr_addr === e.a && wr_data === e.d && clear_busy === e.busy)
          passed++;
        else
          $display("FAIL writeback: got wr=%b a=%0d d=%h busy=%b want wr=%b a=%0d d=%h busy=%b (t=%0t)",
                   Reg_wr, wr_addr, wr_data, clear_busy, e.wr, e.a, e.d, e.busy, $time);
      end
    end
  end

  initial begin
    // Power-up reset, then the full zero-fill with no requests.
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    model_reset();
    repeat (9) step();

    // Both requesters valid continuously: grants alternate 0,1,0,1.
    set_req(0, 1'b1, 3'd3, 2'b11, 16'hAAAA);
    set_req(1, 1'b1, 3'd5, 2'b11, 16'h5555);
    repeat (4) step();
    idle();
    step();

    // Partial byte enable.
    set_req(0, 1'b1, 3'd2, 2'b01, 16'h1234);
    step();
    idle();
    step();

    // Zero byte enable: accepted but no write strobes.
    set_req(0, 1'b1, 3'd1, 2'b00, 16'hBEEF);
    step();
    idle();
    step();

    // clear_req together with a request from requester 1.
    set_req(1, 1'b1, 3'd6, 2'b11, 16'hC0DE);
    clear_req = 1'b1;
    step();
    // clear_req and requests during the fill must be ignored.
    set_req(0, 1'b1, 3'd4, 2'b11, 16'h1111);
    repeat (3) step();
    idle();
    repeat (6) step();

    // Reset while fill address 4 is about to issue.
    do_reset();
    repeat (4) step();
    do_reset();
    repeat (9) step();

    // Randomised traffic with occasional clears and resets.
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      if ($urandom_range(0, 99) == 0) do_reset();
      step();
    end

    idle();
    repeat (10) step();

    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
